mp_sync_receiver: RTL

//  Clocked terminus of a two-phase (transition-signalling) bundled-data micropipeline.

---
 rtl/mp_pkg.sv | 21 ++
 rtl/mp_sync.sv | 29 ++
 rtl/mp_sync_receiver.sv | 104 ++++++++++
 3 files changed

// File: rtl/mp_pkg.sv
// mp_pkg: shared definitions for sync-side endpoints of two-phase
// (transition-signalling) bundled-data micropipelines.
//   MP_DW           default data word width
//   MP_SYNC_STAGES  default depth of the request synchroniser
//   phase_t         1-bit two-phase request/acknowledge level
//   phase_mismatch  true when a request phase differs from the local ack
//                   phase, i.e. a word is outstanding
package mp_pkg;

    localparam int unsigned MP_DW          = 8;
    localparam int unsigned MP_SYNC_STAGES = 2;

    typedef logic phase_t;

    // Two-phase signalling carries events as level differences, so
    // "request pending" is a comparison of levels, never an edge.
    function automatic logic phase_mismatch(input phase_t req, input phase_t ack);
        return req != ack;
    endfunction

endpackage

// File: rtl/mp_sync.sv
// mp_sync: STAGES-deep flop synchroniser for a single asynchronous level.
//   clk  in   sampling clock
//   rst  in   asynchronous active-high reset, all stages cleared to 0
//   d    in   asynchronous input level
//   q    out  synchronised level, STAGES rising edges after d settles
module mp_sync
    import mp_pkg::*;
#(
    parameter int unsigned STAGES = MP_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/mp_sync_receiver.sv
// mp_sync_receiver: clocked terminus of a two-phase bundled-data micropipeline.
// Each req_in transition offers one data_in word. The request is synchronised,
// the word is captured into a DEPTH-entry FIFO, ack_out toggles once per
// accepted word and the FIFO head is offered on a valid/ready port.
//   clk        in   single clock, all state on the rising edge
//   rst        in   asynchronous active-high reset
//   req_in     in   two-phase request, one transition per word
//   data_in    in   bundled data, stable until the matching ack_out transition
//   ack_out    out  two-phase acknowledge
//   out_valid  out  FIFO head available
//   out_data   out  FIFO head word
//   out_ready  in   sink accepts the head when out_valid & out_ready at an edge
//   stall      out  word pending but FIFO full (ack withheld)
module mp_sync_receiver
    import mp_pkg::*;
#(
    parameter int unsigned DW          = MP_DW,
    parameter int unsigned SYNC_STAGES = MP_SYNC_STAGES,
    parameter int unsigned DEPTH       = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_in,
    input  logic [DW-1:0] data_in,
    output logic          ack_out,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          stall
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    phase_t        req_s;
    phase_t        ack;

    logic full;
    logic pending;
    logic push;
    logic pop;

    mp_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (req_in),
        .q  (req_s)
    );

    // Full comes from the registered count, so a pop in the same cycle
    // cannot free a slot for a push; the push follows one cycle later.
    assign full    = (count == FULL_COUNT);
    assign pending = phase_mismatch(req_s, ack);
    assign push    = pending & ~full;
    assign pop     = out_valid & out_ready;

    // Toggling ack on push makes req_s == ack afterwards, so one request
    // phase can never be captured twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ack    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                ack    <= ~ack;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // data_in is sampled without synchronisation: the bundling constraint
    // plus the synchroniser delay guarantee it has settled by the push edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign ack_out   = ack;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign stall     = pending & full;

endmodule
